// File: rtl/cpu_status_flags.sv
// 6502 processor status register (P) with flag update priority, BIT/PLP handling,
// a delayed IRQ mask and NMI edge capture for the control sequencer.
module cpu_status_flags #(
    parameter logic RESET_D = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RDY,
    input  logic       sync,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_op,
    input  logic       plp,
    input  logic [7:0] di,
    input  logic       flag_en,
    input  logic [2:0] flag_op,
    input  logic       push_b,
    input  logic       int_ack,
    input  logic       irq_n,
    input  logic       nmi_n,
    output logic [7:0] P,
    output logic [7:0] P_push,
    output logic       CI,
    output logic       BCD,
    output logic       irq_take,
    output logic       nmi_take
);

    logic n_r, v_r, d_r, i_r, z_r, c_r;
    logic i_mask_r, irq_lvl_r, nmi_pend_r, nmi_prev_r;
    logic n_nxt_s, v_nxt_s, d_nxt_s, i_nxt_s, z_nxt_s, c_nxt_s;
    logic clc_s, sec_s, cli_s, sei_s, cld_s, sed_s, clv_s;
    logic nmi_edge_s, nmi_pend_nxt_s;

    // Decode the flag-set/clear instruction strobe.
    always_comb begin
        clc_s = 1'b0;
        sec_s = 1'b0;
        cli_s = 1'b0;
        sei_s = 1'b0;
        cld_s = 1'b0;
        sed_s = 1'b0;
        clv_s = 1'b0;
        if (flag_en) begin
            case (flag_op)
                3'd0:    clc_s = 1'b1;
                3'd1:    sec_s = 1'b1;
                3'd2:    cli_s = 1'b1;
                3'd3:    sei_s = 1'b1;
                3'd4:    cld_s = 1'b1;
                3'd5:    sed_s = 1'b1;
                3'd6:    clv_s = 1'b1;
                default: clc_s = 1'b0;
            endcase
        end else begin
            clc_s = 1'b0;
        end
    end

    // Per-flag next value; each chain is ordered plp > int_ack > flag_op > bit_op > alu.
    always_comb begin
        n_nxt_s = n_r;
        v_nxt_s = v_r;
        d_nxt_s = d_r;
        i_nxt_s = i_r;
        z_nxt_s = z_r;
        c_nxt_s = c_r;

        if (plp)          n_nxt_s = di[7];
        else if (bit_op)  n_nxt_s = di[7];
        else if (upd_nz)  n_nxt_s = alu_n;
        else              n_nxt_s = n_r;

        if (plp)          v_nxt_s = di[6];
        else if (clv_s)   v_nxt_s = 1'b0;
        else if (bit_op)  v_nxt_s = di[6];
        else if (upd_v)   v_nxt_s = alu_v;
        else              v_nxt_s = v_r;

        if (plp)          d_nxt_s = di[3];
        else if (cld_s)   d_nxt_s = 1'b0;
        else if (sed_s)   d_nxt_s = 1'b1;
        else              d_nxt_s = d_r;

        // Interrupt entry sets I but leaves D alone, as the NMOS part does.
        if (plp)          i_nxt_s = di[2];
        else if (int_ack) i_nxt_s = 1'b1;
        else if (cli_s)   i_nxt_s = 1'b0;
        else if (sei_s)   i_nxt_s = 1'b1;
        else              i_nxt_s = i_r;

        if (plp)          z_nxt_s = di[1];
        else if (bit_op)  z_nxt_s = alu_z;
        else if (upd_nz)  z_nxt_s = alu_z;
        else              z_nxt_s = z_r;

        if (plp)          c_nxt_s = di[0];
        else if (clc_s)   c_nxt_s = 1'b0;
        else if (sec_s)   c_nxt_s = 1'b1;
        else if (upd_c)   c_nxt_s = alu_co;
        else              c_nxt_s = c_r;
    end

    // A fresh falling edge outranks the acknowledge that would retire the request.
    always_comb begin
        nmi_edge_s     = nmi_prev_r & ~nmi_n;
        nmi_pend_nxt_s = nmi_pend_r;
        if (nmi_edge_s)
            nmi_pend_nxt_s = 1'b1;
        else if (int_ack && RDY)
            nmi_pend_nxt_s = 1'b0;
        else
            nmi_pend_nxt_s = nmi_pend_r;
    end

    // Flag, mask and IRQ level registers; frozen while RDY is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_r       <= 1'b0;
            v_r       <= 1'b0;
            d_r       <= RESET_D;
            i_r       <= 1'b1;
            z_r       <= 1'b0;
            c_r       <= 1'b0;
            i_mask_r  <= 1'b1;
            irq_lvl_r <= 1'b0;
        end else if (RDY) begin
            n_r       <= n_nxt_s;
            v_r       <= v_nxt_s;
            d_r       <= d_nxt_s;
            i_r       <= i_nxt_s;
            z_r       <= z_nxt_s;
            c_r       <= c_nxt_s;
            irq_lvl_r <= ~irq_n;
            if (sync)
                i_mask_r <= i_r;
        end
    end

    // NMI edge detector runs every clock, independent of RDY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_prev_r <= 1'b1;
            nmi_pend_r <= 1'b0;
        end else begin
            nmi_prev_r <= nmi_n;
            nmi_pend_r <= nmi_pend_nxt_s;
        end
    end

    // Status images and request outputs decoded from the registers.
    always_comb begin
        P        = {n_r, v_r, 1'b1, 1'b0,   d_r, i_r, z_r, c_r};
        P_push   = {n_r, v_r, 1'b1, push_b, d_r, i_r, z_r, c_r};
        CI       = c_r;
        BCD      = d_r;
        irq_take = irq_lvl_r & ~i_mask_r & ~nmi_pend_r;
        nmi_take = nmi_pend_r;
    end

endmodule

// File: tb/tb_cpu_status_flags.sv
// Directed bench for cpu_status_flags: hand-computed P images and interrupt
// request levels checked one cycle after each stimulus.
module tb_cpu_status_flags;

    logic       clk = 1'b0;
    logic       reset, RDY, sync;
    logic       alu_co, alu_v, alu_z, alu_n;
    logic       upd_nz, upd_c, upd_v, bit_op, plp;
    logic [7:0] di;
    logic       flag_en;
    logic [2:0] flag_op;
    logic       push_b, int_ack, irq_n, nmi_n;
    logic [7:0] P, P_push;
    logic       CI, BCD, irq_take, nmi_take;

    int checks_r = 0;
    int errors_r = 0;

    cpu_status_flags #(.RESET_D(1'b0)) dut (
        .clk(clk), .reset(reset), .RDY(RDY), .sync(sync),
        .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op),
        .plp(plp), .di(di), .flag_en(flag_en), .flag_op(flag_op),
        .push_b(push_b), .int_ack(int_ack), .irq_n(irq_n), .nmi_n(nmi_n),
        .P(P), .P_push(P_push), .CI(CI), .BCD(BCD),
        .irq_take(irq_take), .nmi_take(nmi_take)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic clear_strobes();
        sync = 1'b0; upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0;
        bit_op = 1'b0; plp = 1'b0; flag_en = 1'b0; flag_op = 3'd7;
        int_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    initial begin
        reset = 1'b0; RDY = 1'b1; di = 8'h00; push_b = 1'b0;
        alu_co = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
        irq_n = 1'b1; nmi_n = 1'b1;
        clear_strobes();

        // asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check_eq("rst_P", P, 8'h24);
        check_eq("rst_CI", {7'd0, CI}, 8'h00);
        check_eq("rst_BCD", {7'd0, BCD}, 8'h00);
        check_eq("rst_irq", {7'd0, irq_take}, 8'h00);
        check_eq("rst_nmi", {7'd0, nmi_take}, 8'h00);
        @(posedge clk); #1 reset = 1'b0;

        // ALU path
        alu_co = 1'b1; alu_z = 1'b1; alu_n = 1'b0; upd_nz = 1'b1; upd_c = 1'b1;
        tick();
        check_eq("alu_P", P, 8'h27);
        check_eq("alu_CI", {7'd0, CI}, 8'h01);
        RDY = 1'b0; alu_co = 1'b0; alu_z = 1'b0; alu_n = 1'b1; upd_nz = 1'b1; upd_c = 1'b1;
        tick();
        check_eq("stall_P", P, 8'h27);
        RDY = 1'b1;

        // PLP then BIT (bit_op outranks upd_nz/upd_v)
        plp = 1'b1; di = 8'hFF;
        tick();
        check_eq("plp_P", P, 8'hEF);
        check_eq("plp_BCD", {7'd0, BCD}, 8'h01);
        bit_op = 1'b1; di = 8'h40; alu_z = 1'b1; alu_n = 1'b1; alu_v = 1'b0;
        upd_nz = 1'b1; upd_v = 1'b1;
        tick();
        check_eq("bit_P", P, 8'h6F);
        push_b = 1'b1;
        #1 check_eq("push_b1", P_push, 8'h7F);
        push_b = 1'b0;
        #1 check_eq("push_b0", P_push, 8'h6F);

        // I-mask delay
        irq_n = 1'b0;
        tick();
        check_eq("irq_masked", {7'd0, irq_take}, 8'h00);
        flag_en = 1'b1; flag_op = 3'd2;
        tick();
        check_eq("cli_P", P, 8'h6B);
        check_eq("cli_irq0", {7'd0, irq_take}, 8'h00);
        tick();
        check_eq("cli_nosync", {7'd0, irq_take}, 8'h00);
        sync = 1'b1;
        tick();
        check_eq("cli_sync", {7'd0, irq_take}, 8'h01);
        flag_en = 1'b1; flag_op = 3'd3;
        tick();
        check_eq("sei_P", P, 8'h6F);
        check_eq("sei_irq1", {7'd0, irq_take}, 8'h01);
        sync = 1'b1;
        tick();
        check_eq("sei_sync", {7'd0, irq_take}, 8'h00);
        flag_en = 1'b1; flag_op = 3'd2;
        tick();
        sync = 1'b1;
        tick();
        check_eq("irq_again", {7'd0, irq_take}, 8'h01);

        // NMI edge, held low
        nmi_n = 1'b0;
        tick();
        check_eq("nmi_set", {7'd0, nmi_take}, 8'h01);
        check_eq("nmi_blk_irq", {7'd0, irq_take}, 8'h00);
        for (int i = 0; i < 9; i++) tick();
        check_eq("nmi_held", {7'd0, nmi_take}, 8'h01);
        int_ack = 1'b1;
        tick();
        check_eq("nmi_ack", {7'd0, nmi_take}, 8'h00);
        check_eq("ack_I", {7'd0, P[2]}, 8'h01);
        check_eq("ack_irq_delay", {7'd0, irq_take}, 8'h01);
        for (int i = 0; i < 5; i++) tick();
        check_eq("nmi_once", {7'd0, nmi_take}, 8'h00);

        // edge on the int_ack cycle keeps the request
        nmi_n = 1'b1;
        tick();
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        tick();
        check_eq("nmi_pend2", {7'd0, nmi_take}, 8'h01);
        nmi_n = 1'b0; int_ack = 1'b1;
        tick();
        check_eq("nmi_edge_ack", {7'd0, nmi_take}, 8'h01);
        int_ack = 1'b1;
        tick();
        check_eq("nmi_ack2", {7'd0, nmi_take}, 8'h00);

        // NMI logic runs while stalled; int_ack is ignored
        RDY = 1'b0; nmi_n = 1'b1;
        tick();
        nmi_n = 1'b0;
        tick();
        check_eq("nmi_stall", {7'd0, nmi_take}, 8'h01);
        int_ack = 1'b1;
        tick();
        check_eq("ack_stall", {7'd0, nmi_take}, 8'h01);
        RDY = 1'b1; nmi_n = 1'b1;

        // mid-instruction reset discards pending NMI
        #2 reset = 1'b1;
        #1;
        check_eq("rst2_P", P, 8'h24);
        check_eq("rst2_nmi", {7'd0, nmi_take}, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        irq_n = 1'b1;

        // priority: plp over SEC and upd_c; int_ack over CLI
        plp = 1'b1; di = 8'h00; flag_en = 1'b1; flag_op = 3'd1; upd_c = 1'b1; alu_co = 1'b1;
        tick();
        check_eq("prio_plp", P, 8'h20);
        check_eq("prio_CI", {7'd0, CI}, 8'h00);
        int_ack = 1'b1; flag_en = 1'b1; flag_op = 3'd2;
        tick();
        check_eq("prio_ack", P, 8'h24);

        // remaining flag ops
        flag_en = 1'b1; flag_op = 3'd5;
        tick();
        check_eq("sed_P", P, 8'h2C);
        flag_en = 1'b1; flag_op = 3'd1;
        tick();
        check_eq("sec_P", P, 8'h2D);
        flag_en = 1'b1; flag_op = 3'd7;
        tick();
        check_eq("nop_P", P, 8'h2D);
        flag_en = 1'b1; flag_op = 3'd4;
        tick();
        check_eq("cld_P", P, 8'h25);
        upd_v = 1'b1; alu_v = 1'b1;
        tick();
        check_eq("updv_P", P, 8'h65);
        flag_en = 1'b1; flag_op = 3'd6; upd_v = 1'b1; alu_v = 1'b1;
        tick();
        check_eq("clv_P", P, 8'h25);
        flag_en = 1'b1; flag_op = 3'd0;
        tick();
        check_eq("clc_P", P, 8'h24);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
